// File: rtl/data_memory_pkg.sv
// Shared definitions for the synchronous data memory.
//   - Access-size encodings used on the size port.
//   - Lane-mask constants for byte, half and word stores.
//   - write_mask(): 4-bit byte-lane write mask from size and address[1:0].
package data_memory_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Lane mask for a store. Halves always start on an even lane, so only
  // lane[1] selects the half; alignment is checked separately.
  function automatic logic [3:0] write_mask(input logic [1:0] size,
                                            input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = MASK_BYTE << lane;
      SZ_HALF: m = MASK_HALF << {lane[1], 1'b0};
      SZ_WORD: m = MASK_WORD;
      default: m = MASK_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_sync_load_align.sv
// mem_load_align: combinational load formatter.
//   word_i     : full 32-bit word read from the array.
//   lane_i     : address[1:0] of the load.
//   size_i     : access size (byte / half / word).
//   unsigned_i : 1 = zero-extend, 0 = sign-extend (ignored for words).
//   result_o   : right-aligned, extended load result.
module mem_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = word_i[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = lanes[lane_i];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_sync.sv
// data_memory_sync: byte-addressed data memory for the MEM stage.
//   clk, reset     : rising-edge clock, synchronous active-high reset.
//   address        : byte address (word index = address[ADDR_W-1:2]).
//   writeData      : right-aligned store data.
//   memRead/Write  : load / store request for this cycle.
//   size           : 00 byte, 01 half, 10 word, 11 reserved.
//   unsignedLoad   : zero-extend (1) or sign-extend (0) byte/half loads.
//   readData       : load result, one cycle after the accepting edge.
//   readValid      : pulse, readData updated this cycle.
//   accessError    : pulse, previous cycle's request was rejected.
//   errCount       : saturating count of rejected requests.
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    address,
  input  logic [31:0]          writeData,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [1:0]           size,
  input  logic                 unsignedLoad,
  output logic [31:0]          readData,
  output logic                 readValid,
  output logic                 accessError,
  output logic [ERR_CNT_W-1:0] errCount
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0] memoria [0:DEPTH-1];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             out_of_range;
  logic             misaligned;
  logic             req;
  logic             reject;
  logic             do_load;
  logic             do_store;
  logic [3:0]       wmask;
  logic [31:0]      wdata_rep;

  logic [31:0]          rd_word_q;
  logic [1:0]           ld_lane_q, ld_lane_d;
  logic [1:0]           ld_size_q, ld_size_d;
  logic                 ld_uns_q, ld_uns_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign word_idx = address[IDX_W+1:2];
  assign lane     = address[1:0];

  // Any set bit above the array's index field means the word does not exist.
  generate
    if (ADDR_W - 2 > IDX_W) begin : g_range
      assign out_of_range = |address[ADDR_W-1:IDX_W+2];
    end else begin : g_norange
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign misaligned = ((size == SZ_HALF) && lane[0]) ||
                      ((size == SZ_WORD) && (lane != 2'b00));
  assign req      = memRead | memWrite;
  assign reject   = req && ((memRead && memWrite) || (size == SZ_RSVD) ||
                            misaligned || out_of_range);
  assign do_load  = !reset && req && !reject && memRead;
  assign do_store = !reset && req && !reject && memWrite;
  assign wmask    = write_mask(size, lane);

  // Replicate the store data so every lane carries the right byte; the
  // mask then decides which lanes actually land in the array.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rep
      assign wdata_rep[8*gi +: 8] =
        (size == SZ_BYTE) ? writeData[7:0] :
        (size == SZ_HALF) ? writeData[8*(gi%2) +: 8] :
                            writeData[8*gi +: 8];
    end
  endgenerate

  // Array write port: byte-enabled, no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) memoria[word_idx][8*k +: 8] <= wdata_rep[8*k +: 8];
      end
    end
  end

  // Registered read port. The raw word is held and formatted afterwards,
  // so it only changes on an accepted load and readData holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word_q <= '0;
    end else if (do_load) begin
      rd_word_q <= memoria[word_idx];
    end
  end

  always_comb begin
    ld_lane_d = ld_lane_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    if (do_load) begin
      ld_lane_d = lane;
      ld_size_d = size;
      ld_uns_d  = unsignedLoad;
    end
    rvalid_d  = do_load;
    err_d     = reject;
    err_cnt_d = err_cnt_q;
    if (reject && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_lane_q <= '0;
      ld_size_q <= SZ_BYTE;
      ld_uns_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      ld_lane_q <= ld_lane_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // A zero raw word formats to zero for every size, so readData is 0 after reset.
  mem_load_align u_align (
    .word_i     (rd_word_q),
    .lane_i     (ld_lane_q),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .result_o   (readData)
  );

  // Strobes are suppressed while reset is held, so a load accepted just
  // before reset never reports valid data.
  assign readValid   = rvalid_q & ~reset;
  assign accessError = err_q & ~reset;
  assign errCount    = err_cnt_q;

endmodule

// File: doc/data_memory_sync.md
Name: data_memory_sync

Overview:
- Synchronous, byte-addressed data memory for the datapath MEM stage.
- Parametrised successor of the word-only, combinational-read DATAMEMORY.
- Adds byte/half/word loads and stores, signed or unsigned load extension, and registered reads with a valid strobe.
- Adds misaligned and out-of-range detection with a saturating error counter.

Parameters:
- ADDR_W, 32, width of the byte address.
- DEPTH, 64, number of 32-bit words in the array (power of two, at least 4).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  byte address.
- writeData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- memRead  input  1  load request this cycle.
- memWrite  input  1  store request this cycle.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- unsignedLoad  input  1  1 = zero-extend the load, 0 = sign-extend; ignored for word loads.
- readData  output  32  registered load result.
- readValid  output  1  one-cycle pulse: readData was updated this cycle.
- accessError  output  1  one-cycle pulse: the previous cycle's request was rejected.
- errCount  output  ERR_CNT_W  saturating count of rejected requests.

Behaviour:
- Storage: array "memoria" [0:DEPTH-1] of 32 bits. The bench preloads it with $readmemb. Reset does not clear it.
- Word index = address[ADDR_W-1:2]. Lane = address[1:0]. Little-endian: byte lane k = bits [8k+7:8k].
- Request accepted at a rising edge when reset=0 and (memRead or memWrite) = 1.
- Rejection conditions (any one rejects the request):
  - memRead and memWrite both high.
  - size = 11.
  - Half access with address[0] = 1.
  - Word access with address[1:0] != 0.
  - Word index >= DEPTH.
- Rejected request:
  - No array write; readData holds.
  - readValid = 0.
  - Next cycle: accessError = 1 and errCount += 1, saturating at all-ones.
- Store:
  - Array updated at the accepting edge.
  - Only the addressed lanes are written: byte writes 1 lane, half writes lanes {a1,0}+0..1, word writes all 4.
  - Source data = writeData[7:0] replicated per byte / [15:0] per half.
  - readValid = 0.
- Load:
  - Latency 1: the array is read at the accepting edge, so result and readValid = 1 appear in the following cycle.
  - Byte/half extracted from the addressed lane, then extended per unsignedLoad.
  - readData holds its value until the next accepted load.
- Read-after-write: a store at edge N followed by a load at edge N+1 returns the new data (no forwarding required).
- Idle cycle (no request): readValid = 0, accessError = 0, readData holds.
- Reset:
  - readData = 0, readValid = 0, accessError = 0, errCount = 0.
  - A request present in a reset cycle is ignored: no write, not counted.
  - A load accepted the cycle before reset produces no readValid.
- No X propagation: reads of unwritten, unpreloaded words return the array content as-is; no checking is required.

Decomposition:
- Package data_memory_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - Lane-mask constants.
  - Function computing the 4-bit write mask from size and address[1:0].
- Sub-module mem_load_align (combinational):
  - Inputs: 32-bit word, address[1:0], size, unsignedLoad.
  - Output: extended 32-bit result.
  - Instantiated once; unit-testable standalone.
- Top module holds the array, request decode, error logic, output registers and counter.

Test Plan:
1. Preload memoria[0]=32'h804020F1; lw addr 0 -> next cycle readData=32'h804020F1, readValid=1, accessError=0.
2. lb addr 0 -> 32'hFFFFFFF1. lbu addr 0 -> 32'h000000F1. lh addr 2 -> 32'hFFFF8040. lhu addr 2 -> 32'h00008040. lb addr 3 -> 32'hFFFFFF80.
3. memoria[1]=0; sb addr 5 data 32'h123456AB; next cycle lw addr 4 -> 32'h0000AB00. sh addr 6 data 32'hCAFE -> lw addr 4 = 32'hCAFEAB00.
4. lw addr 2 -> readValid=0, accessError=1, errCount=1. sh addr 3 data 32'hFFFF -> no write, errCount=2. size=11 -> errCount=3.
5. lw addr 4*DEPTH (256) -> error. memRead=memWrite=1 at addr 0 -> error, memoria[0] unchanged. Drive 260 consecutive errors -> errCount holds 255.
6. Assert reset on a cycle with sw addr 8 data 32'hDEADBEEF -> memoria[2] unchanged; all outputs 0 next cycle. Load issued the cycle before reset -> readValid stays 0.
